// File: rtl/vram_pkg.sv
// Shared constants and types for the VRAM arbiter slice.
package vram_pkg;

  localparam int ADDR_W         = 16;
  localparam int DATA_W         = 6;
  localparam int FB_WORDS       = 61440;
  localparam int FIFO_DEPTH_DEF = 8;

  localparam logic [ADDR_W-1:0] FB_LIMIT = ADDR_W'(FB_WORDS);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_READ  = 2'd1,
    SLOT_WRITE = 2'd2
  } slot_t;

  // Addresses at or above FB_WORDS have no backing RAM word.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return a < FB_LIMIT;
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of the VGA read port, PPU write port, framebuffer RAM port and
// FIFO occupancy. The master modport is the arbiter; slave is its surroundings.
interface vram_arbiter_if #(
  parameter int FIFO_DEPTH = vram_pkg::FIFO_DEPTH_DEF
);
  import vram_pkg::*;

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic [LVL_W-1:0]  fifo_level;

  modport master (
    input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, ram_rdata,
    output rd_data, wr_ready, ram_addr, ram_we, ram_wdata, fifo_level
  );

  modport slave (
    output rd_req, rd_addr, wr_valid, wr_addr, wr_data, ram_rdata,
    input  rd_data, wr_ready, ram_addr, ram_we, ram_wdata, fifo_level
  );

endinterface

// File: rtl/vram_wr_fifo.sv
// PPU write FIFO: circular buffer with count-based full/empty.
// With VRAM_FWD_EN defined, all entries are also exposed in age order
// (index 0 = head) with per-entry valid bits for the read-forwarding search.
module vram_wr_fifo
  import vram_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                   PCK,
  input  logic                   RST,
  input  logic                   i_push,
  input  wr_entry_t              i_push_entry,
  input  logic                   i_pop,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count,
  output wr_entry_t              o_head
`ifdef VRAM_FWD_EN
  ,
  output wr_entry_t [DEPTH-1:0]  o_entries,
  output logic [DEPTH-1:0]       o_entry_valid
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wr_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Pointers and occupancy; reset discards everything queued.
  always_ff @(posedge PCK or negedge RST) begin
    if (!RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset: only slots below r_count are ever read.
  always_ff @(posedge PCK) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_entry;
  end

`ifdef VRAM_FWD_EN
  // Age-ordered view of the queue for the forwarding search.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      o_entries[i]     = r_mem[r_rd_ptr + PTR_W'(i)];
      o_entry_valid[i] = (CNT_W'(i) < r_count);
    end
  end
`endif

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates the single-port framebuffer RAM between VGA scan-out reads
// (strict priority, repeated addresses coalesced) and buffered PPU writes
// that drain in free slots. Read latency is 2 cycles.
// Build option: VRAM_FWD_EN -- a read also picks up the youngest queued
// write to the same address instead of the stale RAM word.
//
//  slot       | meaning
//  -----------+-------------------------------------------------------
//  SLOT_READ  | new VGA address; RAM read (none if out of range)
//  SLOT_WRITE | no new read; FIFO head popped, written if in range
//  SLOT_IDLE  | nothing to do; RAM address bus holds its last value
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic          PCK,
  input  logic          RST,
  vram_arbiter_if.master bus
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              r_run;
  logic              r_last_valid;
  logic [ADDR_W-1:0] r_last_addr;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_p1_valid;
  logic              r_p1_zero;
  logic [DATA_W-1:0] r_rd_data;

  slot_t             w_slot;
  logic              w_hit;
  logic              w_rd_in_range;
  logic              w_wr_in_range;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic              w_push;
  logic              w_pop;
  wr_entry_t         w_push_entry;
  wr_entry_t         w_head;
  logic [LVL_W-1:0]  w_level;
  logic [ADDR_W-1:0] w_ram_addr;
  logic              w_ram_we;
  logic [DATA_W-1:0] w_p1_data;

`ifdef VRAM_FWD_EN
  wr_entry_t [FIFO_DEPTH-1:0] w_entries;
  logic [FIFO_DEPTH-1:0]      w_entry_valid;
  logic                       w_fwd_hit;
  logic [DATA_W-1:0]          w_fwd_data;
  logic                       r_p1_fwd;
  logic [DATA_W-1:0]          r_p1_fwd_data;
`endif

  assign w_push_entry = '{addr: bus.wr_addr, data: bus.wr_data};
  assign w_push       = bus.wr_valid && bus.wr_ready;
  assign w_pop        = (w_slot == SLOT_WRITE);

  vram_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .PCK           (PCK),
    .RST           (RST),
    .i_push        (w_push),
    .i_push_entry  (w_push_entry),
    .i_pop         (w_pop),
    .o_empty       (w_fifo_empty),
    .o_full        (w_fifo_full),
    .o_count       (w_level),
    .o_head        (w_head)
`ifdef VRAM_FWD_EN
    ,
    .o_entries     (w_entries),
    .o_entry_valid (w_entry_valid)
`endif
  );

  // r_run keeps wr_ready low while reset is held, even though the FIFO is empty.
  assign bus.wr_ready   = r_run && !w_fifo_full;
  assign bus.fifo_level = w_level;
  assign bus.rd_data    = r_rd_data;

  assign w_hit         = r_last_valid && (bus.rd_addr == r_last_addr);
  assign w_rd_in_range = addr_in_range(bus.rd_addr);
  assign w_wr_in_range = addr_in_range(w_head.addr);

  // Slot decision: new reads first, then FIFO drain, else idle.
  always_comb begin
    w_slot = SLOT_IDLE;
    if (bus.rd_req && !w_hit) begin
      w_slot = SLOT_READ;
    end else if (!w_fifo_empty) begin
      w_slot = SLOT_WRITE;
    end
  end

  // RAM port drive; out-of-range accesses leave the bus untouched.
  always_comb begin
    w_ram_addr = r_ram_addr;
    w_ram_we   = 1'b0;
    if (w_slot == SLOT_READ && w_rd_in_range) begin
      w_ram_addr = bus.rd_addr;
    end else if (w_slot == SLOT_WRITE && w_wr_in_range) begin
      w_ram_addr = w_head.addr;
      w_ram_we   = 1'b1;
    end
  end

  assign bus.ram_addr  = w_ram_addr;
  assign bus.ram_we    = w_ram_we;
  assign bus.ram_wdata = w_head.data;

`ifdef VRAM_FWD_EN
  // Youngest queued write to the read address wins; later indices are younger.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (w_entry_valid[i] && (w_entries[i].addr == bus.rd_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = w_entries[i].data;
      end
    end
  end

  // Forwarded data rides alongside the RAM read for one cycle.
  always_ff @(posedge PCK or negedge RST) begin
    if (!RST) begin
      r_p1_fwd      <= 1'b0;
      r_p1_fwd_data <= '0;
    end else if (w_slot == SLOT_READ) begin
      r_p1_fwd      <= w_fwd_hit;
      r_p1_fwd_data <= w_fwd_data;
    end
  end

  assign w_p1_data = r_p1_fwd ? r_p1_fwd_data : bus.ram_rdata;
`else
  assign w_p1_data = bus.ram_rdata;
`endif

  // Coalescing tag, held RAM address and the two-stage read pipeline.
  always_ff @(posedge PCK or negedge RST) begin
    if (!RST) begin
      r_run        <= 1'b0;
      r_last_valid <= 1'b0;
      r_last_addr  <= '0;
      r_ram_addr   <= '0;
      r_p1_valid   <= 1'b0;
      r_p1_zero    <= 1'b0;
      r_rd_data    <= '0;
    end else begin
      r_run      <= 1'b1;
      r_ram_addr <= w_ram_addr;

      if (w_slot == SLOT_READ) begin
        r_last_addr  <= bus.rd_addr;
        r_last_valid <= w_rd_in_range;
      end else if (w_slot == SLOT_WRITE && w_head.addr == r_last_addr) begin
        // The word VGA is showing just changed; force the next read to RAM.
        r_last_valid <= 1'b0;
      end

      r_p1_valid <= (w_slot == SLOT_READ);
      r_p1_zero  <= !w_rd_in_range;

      if (r_p1_valid) begin
        r_rd_data <= r_p1_zero ? '0 : w_p1_data;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: framebuffer RAM model, write/read scoreboards,
// one task per scenario.
module tb_vram_arbiter;
  import vram_pkg::*;

  logic PCK = 1'b0;
  logic RST = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 PCK = ~PCK;
  always @(posedge PCK) cyc <= cyc + 1;

  vram_arbiter_if #(.FIFO_DEPTH(8)) bus ();

  vram_arbiter #(.FIFO_DEPTH(8)) dut (
    .PCK (PCK),
    .RST (RST),
    .bus (bus)
  );

  // Framebuffer RAM model with a backdoor preload port.
  logic [5:0]  fb [0:65535];
  logic        bd_we = 1'b0;
  logic [15:0] bd_addr = '0;
  logic [5:0]  bd_data = '0;

  always @(posedge PCK) begin
    if (bd_we) fb[bd_addr] <= bd_data;
    else if (bus.ram_we) fb[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= fb[bus.ram_addr];
  end

  typedef struct { logic [15:0] addr; logic [5:0] data; } wr_exp_t;
  typedef struct { int due; logic [5:0] data; } rd_exp_t;
  wr_exp_t wr_q[$];
  rd_exp_t rd_q[$];
  wr_exp_t mon_w;
  rd_exp_t mon_r;

  // Scoreboards: RAM writes in acceptance order, rd_data at its due cycle.
  always @(negedge PCK) begin
    if (bus.ram_we) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: ram_we addr=%h data=%h, required no write", bus.ram_addr, bus.ram_wdata);
      end else begin
        mon_w = wr_q.pop_front();
        if (bus.ram_addr !== mon_w.addr || bus.ram_wdata !== mon_w.data) begin
          errors++;
          $display("FAIL wr_order: addr=%h data=%h, required addr=%h data=%h",
                   bus.ram_addr, bus.ram_wdata, mon_w.addr, mon_w.data);
        end
      end
    end
    if (RST && bus.wr_valid && bus.wr_ready && bus.wr_addr < 16'hF000)
      wr_q.push_back('{addr: bus.wr_addr, data: bus.wr_data});
    while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
      mon_r = rd_q.pop_front();
      checks++;
      if (mon_r.due != cyc || bus.rd_data !== mon_r.data) begin
        errors++;
        $display("FAIL rd_data: cycle %0d rd_data=%h, required %h at cycle %0d",
                 cyc, bus.rd_data, mon_r.data, mon_r.due);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge PCK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rd_req   = 1'b0;
    bus.rd_addr  = '0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
  endtask

  task automatic expect_rd(input logic [5:0] d);
    rd_q.push_back('{due: cyc + 2, data: d});
  endtask

  task automatic preload(input logic [15:0] a, input logic [5:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    step();
    bd_we = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (bus.fifo_level != 0 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (bus.fifo_level != 0) begin
      errors++;
      $display("FAIL %s_drain: fifo_level=%0d, required 0", name, bus.fifo_level);
    end
    step(); step(); step();
  endtask

  task automatic test_reset();
    idle_inputs();
    #12;
    checks += 4;
    if (bus.rd_data !== 6'd0)    begin errors++; $display("FAIL por_rd_data: %h, required 0", bus.rd_data); end
    if (bus.fifo_level !== 4'd0) begin errors++; $display("FAIL por_level: %0d, required 0", bus.fifo_level); end
    if (bus.ram_we !== 1'b0)     begin errors++; $display("FAIL por_ram_we: %b, required 0", bus.ram_we); end
    if (bus.wr_ready !== 1'b0)   begin errors++; $display("FAIL por_wr_ready: %b, required 0", bus.wr_ready); end
    step(); step();
    RST = 1'b1;
    step();
    checks++;
    if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL por_ready_after: %b, required 1", bus.wr_ready); end
  endtask

  task automatic test_reset_midtraffic();
    for (int i = 0; i < 5; i++) begin
      bus.rd_req  = 1'b1;
      bus.rd_addr = 16'h0040 + 16'(i);
      bus.wr_valid = (i >= 1 && i <= 3);
      bus.wr_addr  = 16'h0900 + 16'(i);
      bus.wr_data  = 6'(i);
      if (i < 3) expect_rd(6'h21 + 6'(i));
      @(negedge PCK);
      if (i == 4) begin
        checks++;
        if (bus.fifo_level !== 4'd3) begin errors++; $display("FAIL mid_level: %0d, required 3", bus.fifo_level); end
      end
      step();
    end
    bus.wr_valid = 1'b0;
    RST = 1'b0;
    wr_q.delete();
    rd_q.delete();
    #1;
    checks += 4;
    if (bus.rd_data !== 6'd0)    begin errors++; $display("FAIL mid_rd_data: %h, required 0", bus.rd_data); end
    if (bus.fifo_level !== 4'd0) begin errors++; $display("FAIL mid_level_rst: %0d, required 0", bus.fifo_level); end
    if (bus.ram_we !== 1'b0)     begin errors++; $display("FAIL mid_ram_we: %b, required 0", bus.ram_we); end
    if (bus.wr_ready !== 1'b0)   begin errors++; $display("FAIL mid_wr_ready: %b, required 0", bus.wr_ready); end
    step();
    idle_inputs();
    step();
    RST = 1'b1;
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (bus.fifo_level !== 4'd0) begin errors++; $display("FAIL mid_level_after: %0d, required 0", bus.fifo_level); end
  endtask

  task automatic test_coalesce();
    for (int s = 0; s < 3; s++) begin
      bus.rd_req   = 1'b1;
      bus.rd_addr  = 16'h0A00 + 16'(s);
      bus.wr_valid = (s < 2);
      bus.wr_addr  = 16'h0800 + 16'(s);
      bus.wr_data  = 6'h11 + 6'(s);
      step();
    end
    bus.wr_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.rd_req  = 1'b1;
      bus.rd_addr = (k < 2) ? 16'h0100 : 16'h0101;
      expect_rd((k < 2) ? 6'd5 : 6'd9);
      @(negedge PCK);
      checks++;
      if (k % 2 == 0) begin
        if (bus.ram_we !== 1'b0 || bus.ram_addr !== bus.rd_addr) begin
          errors++;
          $display("FAIL coal_read_slot%0d: we=%b addr=%h, required we=0 addr=%h", k, bus.ram_we, bus.ram_addr, bus.rd_addr);
        end
      end else if (bus.ram_we !== 1'b1) begin
        errors++;
        $display("FAIL coal_write_slot%0d: we=%b, required 1", k, bus.ram_we);
      end
      step();
    end
    idle_inputs();
    drain("coal");
  endtask

  task automatic test_back_to_back();
    int  k = 0;
    logic acc;
    for (int i = 0; i < 12; i++) begin
      bus.rd_req   = (i < 10);
      bus.rd_addr  = 16'h1000 + 16'(i);
      bus.wr_valid = (k < 9);
      bus.wr_addr  = 16'h0400 + 16'(k);
      bus.wr_data  = 6'(k + 1);
      @(negedge PCK);
      acc = bus.wr_valid && bus.wr_ready;
      if (i == 7) begin
        checks++;
        if (bus.wr_ready !== 1'b1 || bus.fifo_level !== 4'd7) begin
          errors++; $display("FAIL b2b_before_full: ready=%b level=%0d, required 1/7", bus.wr_ready, bus.fifo_level);
        end
      end
      if (i == 8) begin
        checks++;
        if (bus.wr_ready !== 1'b0 || bus.fifo_level !== 4'd8) begin
          errors++; $display("FAIL b2b_full: ready=%b level=%0d, required 0/8", bus.wr_ready, bus.fifo_level);
        end
      end
      if (i == 10) begin
        checks++;
        if (bus.ram_we !== 1'b1 || bus.wr_ready !== 1'b0) begin
          errors++; $display("FAIL b2b_first_pop: we=%b ready=%b, required 1/0", bus.ram_we, bus.wr_ready);
        end
      end
      if (i == 11) begin
        checks++;
        if (bus.wr_ready !== 1'b1) begin
          errors++; $display("FAIL b2b_reready: ready=%b, required 1", bus.wr_ready);
        end
      end
      step();
      if (acc) k++;
    end
    idle_inputs();
    checks++;
    if (k != 9) begin errors++; $display("FAIL b2b_accepted: %0d, required 9", k); end
    drain("b2b");
  endtask

  task automatic test_coherence();
    for (int c = 0; c < 4; c++) begin
      bus.rd_req   = 1'b1;
      bus.rd_addr  = 16'h0200;
      bus.wr_valid = (c == 1);
      bus.wr_addr  = 16'h0200;
      bus.wr_data  = 6'd7;
      expect_rd((c == 3) ? 6'd7 : 6'd1);
      @(negedge PCK);
      checks++;
      case (c)
        1: if (bus.ram_we !== 1'b0 || bus.wr_ready !== 1'b1) begin
             errors++; $display("FAIL coh_push: we=%b ready=%b, required 0/1", bus.ram_we, bus.wr_ready);
           end
        2: if (bus.ram_we !== 1'b1) begin
             errors++; $display("FAIL coh_drain: we=%b, required 1", bus.ram_we);
           end
        3: if (bus.ram_we !== 1'b0 || bus.ram_addr !== 16'h0200) begin
             errors++; $display("FAIL coh_reread: we=%b addr=%h, required 0/0200", bus.ram_we, bus.ram_addr);
           end
        default: if (bus.ram_addr !== 16'h0200) begin
             errors++; $display("FAIL coh_first_read: addr=%h, required 0200", bus.ram_addr);
           end
      endcase
      step();
    end
    idle_inputs();
    step(); step(); step();
  endtask

  task automatic test_range();
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 16'hF000;
    bus.wr_data  = 6'd3;
    step();
    bus.wr_valid = 1'b0;
    @(negedge PCK);
    checks++;
    if (bus.ram_we !== 1'b0 || bus.fifo_level !== 4'd1) begin
      errors++; $display("FAIL range_pop: we=%b level=%0d, required 0/1", bus.ram_we, bus.fifo_level);
    end
    step();
    bus.rd_req  = 1'b1;
    bus.rd_addr = 16'hF000;
    expect_rd(6'd0);
    @(negedge PCK);
    checks++;
    if (bus.fifo_level !== 4'd0 || bus.ram_we !== 1'b0) begin
      errors++; $display("FAIL range_after: level=%0d we=%b, required 0/0", bus.fifo_level, bus.ram_we);
    end
    step();
    idle_inputs();
    step(); step(); step();
  endtask

  task automatic test_forward();
    logic [5:0] exp_first;
`ifdef VRAM_FWD_EN
    exp_first = 6'd4;
`else
    exp_first = 6'd1;
`endif
    for (int c = 0; c < 3; c++) begin
      bus.rd_req   = 1'b1;
      bus.rd_addr  = (c < 2) ? (16'h2000 + 16'(c)) : 16'h0300;
      bus.wr_valid = (c < 2);
      bus.wr_addr  = 16'h0300;
      bus.wr_data  = (c == 0) ? 6'd2 : 6'd4;
      if (c == 2) expect_rd(exp_first);
      step();
    end
    idle_inputs();
    drain("fwd");
    bus.rd_req  = 1'b1;
    bus.rd_addr = 16'h0300;
    expect_rd(6'd4);
    step();
    idle_inputs();
    step(); step(); step();
  endtask

  initial begin
    test_reset();
    for (int i = 0; i < 5; i++) preload(16'h0040 + 16'(i), 6'h21 + 6'(i));
    preload(16'h0100, 6'd5);
    preload(16'h0101, 6'd9);
    preload(16'h0200, 6'd1);
    preload(16'h0300, 6'd1);
    test_reset_midtraffic();
    test_coalesce();
    test_back_to_back();
    test_coherence();
    test_range();
    test_forward();
    checks++;
    if (wr_q.size() != 0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: writes=%0d reads=%0d, required 0/0", wr_q.size(), rd_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
